// File: rtl/nitta_spi_slave_pu.sv
// NITTA processing unit: double-buffered word channel between the computational core and an
// external SPI master (mode 0, MSB first). Buffer pairs swap on signal_cycle once cs is high.
module nitta_spi_slave_pu #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ATTR_WIDTH     = 4,
    parameter int unsigned SPI_DATA_WIDTH = 8,
    parameter int unsigned BUF_SIZE       = 8,
    parameter int unsigned BOUNCE_FILTER  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signal_cycle,
    input  logic                  signal_wr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ATTR_WIDTH-1:0] attr_in,
    input  logic                  signal_oe,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ATTR_WIDTH-1:0] attr_out,
    input  logic                  mosi,
    output logic                  miso,
    input  logic                  sclk,
    input  logic                  cs
);
    localparam int unsigned BYTES  = DATA_WIDTH / SPI_DATA_WIDTH;
    localparam int unsigned PTR_W  = $clog2(BUF_SIZE + 1);
    localparam int unsigned IDX_W  = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;
    localparam int unsigned BIT_W  = (SPI_DATA_WIDTH > 1) ? $clog2(SPI_DATA_WIDTH) : 1;
    localparam int unsigned BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned POS_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned FILT_W = $clog2(BOUNCE_FILTER + 1);

    localparam logic [PTR_W-1:0]          BUF_FULL  = PTR_W'(BUF_SIZE);
    localparam logic [SPI_DATA_WIDTH-1:0] FILL_BYTE = SPI_DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0]     FILL_WORD = {BYTES{FILL_BYTE}};
    localparam logic [DATA_WIDTH-1:0]     MSB_MASK  = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    // Index 1 carries cs, index 0 carries sclk; both idle at their inactive levels.
    localparam logic [1:0]                IDLE_LVL  = 2'b10;

    logic unused_attr;
    assign unused_attr = ^attr_in;

    // ------------------------------------------------------------------ synchronisers
    logic [1:0]        sync1_q, sync2_q, filt_q, filt_prev_q;
    logic [FILT_W-1:0] filt_cnt_q [2];
    logic              mosi1_q, mosi2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= IDLE_LVL;
            sync2_q       <= IDLE_LVL;
            filt_q        <= IDLE_LVL;
            filt_prev_q   <= IDLE_LVL;
            filt_cnt_q[0] <= '0;
            filt_cnt_q[1] <= '0;
            mosi1_q       <= 1'b0;
            mosi2_q       <= 1'b0;
        end else begin
            sync1_q     <= {cs, sclk};
            sync2_q     <= sync1_q;
            filt_prev_q <= filt_q;
            mosi1_q     <= mosi;
            mosi2_q     <= mosi1_q;
            // A new level is accepted only after BOUNCE_FILTER consecutive differing samples.
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    filt_cnt_q[i] <= '0;
                end else if (filt_cnt_q[i] == FILT_W'(BOUNCE_FILTER - 1)) begin
                    filt_q[i]     <= sync2_q[i];
                    filt_cnt_q[i] <= '0;
                end else begin
                    filt_cnt_q[i] <= filt_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    logic sclk_rise, sclk_fall, cs_fall, cs_active;
    assign sclk_rise = filt_q[0] & ~filt_prev_q[0];
    assign sclk_fall = ~filt_q[0] & filt_prev_q[0];
    assign cs_fall   = ~filt_q[1] & filt_prev_q[1];
    assign cs_active = ~filt_q[1];

    // ------------------------------------------------------------------ buffers
    // bank_q selects the SPI-fill and core-write halves; the other halves face the
    // core-read and SPI-send sides respectively.
    logic [DATA_WIDTH-1:0] rx_mem [2][BUF_SIZE];
    logic [DATA_WIDTH-1:0] tx_mem [2][BUF_SIZE];
    logic                  bank_q;

    // ------------------------------------------------------------------ core side
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q, rx_count_latched_q, tx_count_q;
    logic [PTR_W-1:0] rx_count_q;
    logic             swap_pending_q;
    logic             rd_valid, rd_hit, wr_hit, do_swap;

    assign rd_valid = rd_ptr_q < rx_count_latched_q;
    assign rd_hit   = signal_oe & rd_valid;
    assign wr_hit   = signal_wr & (wr_ptr_q != BUF_FULL);
    assign do_swap  = (signal_cycle | swap_pending_q) & ~cs_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q             <= 1'b0;
            swap_pending_q     <= 1'b0;
            rd_ptr_q           <= '0;
            wr_ptr_q           <= '0;
            rx_count_latched_q <= '0;
            tx_count_q         <= '0;
        end else begin
            if (rd_hit) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_hit) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_swap) begin
                bank_q             <= ~bank_q;
                swap_pending_q     <= 1'b0;
                rx_count_latched_q <= rx_count_q;
                tx_count_q         <= wr_ptr_q + PTR_W'(wr_hit);
                rd_ptr_q           <= '0;
                wr_ptr_q           <= '0;
            end else if (signal_cycle) begin
                swap_pending_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_hit) tx_mem[bank_q][wr_ptr_q[IDX_W-1:0]] <= data_in;
    end

    always_comb begin
        data_out = '0;
        attr_out = '0;
        if (signal_oe) begin
            if (rd_valid) data_out = rx_mem[~bank_q][rd_ptr_q[IDX_W-1:0]];
            else          attr_out[0] = 1'b1;
        end
    end

    // ------------------------------------------------------------------ SPI receive
    logic [DATA_WIDTH-2:0] rx_shift_q;
    logic [BIT_W-1:0]      rx_bit_q;
    logic [BYTE_W-1:0]     rx_byte_q;
    logic                  rx_byte_done, rx_word_done;

    assign rx_byte_done = rx_bit_q == BIT_W'(SPI_DATA_WIDTH - 1);
    assign rx_word_done = cs_active & sclk_rise & rx_byte_done
                        & (rx_byte_q == BYTE_W'(BYTES - 1));

    // ------------------------------------------------------------------ SPI transmit
    logic [POS_W-1:0]      tx_pos_q, tx_pos_d;
    logic [PTR_W-1:0]      tx_word_q, tx_word_d;
    logic [DATA_WIDTH-1:0] tx_word_data;
    logic                  tx_bit_d, miso_q;

    always_comb begin
        tx_pos_d  = tx_pos_q;
        tx_word_d = tx_word_q;
        if (!cs_active) begin
            tx_pos_d  = '0;
            tx_word_d = '0;
        end else if (sclk_fall) begin
            if (tx_pos_q == POS_W'(DATA_WIDTH - 1)) begin
                tx_pos_d = '0;
                if (tx_word_q != BUF_FULL) tx_word_d = tx_word_q + 1'b1;
            end else begin
                tx_pos_d = tx_pos_q + 1'b1;
            end
        end
        tx_word_data = FILL_WORD;
        if (tx_word_d < tx_count_q) tx_word_data = tx_mem[~bank_q][tx_word_d[IDX_W-1:0]];
        tx_bit_d = |(tx_word_data & (MSB_MASK >> tx_pos_d));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_shift_q <= '0;
            rx_bit_q   <= '0;
            rx_byte_q  <= '0;
            rx_count_q <= '0;
            tx_pos_q   <= '0;
            tx_word_q  <= '0;
            miso_q     <= 1'b0;
        end else begin
            tx_pos_q  <= tx_pos_d;
            tx_word_q <= tx_word_d;
            // Keeps the first bit preloaded while cs is high; afterwards tracks falling edges.
            miso_q    <= tx_bit_d;
            if (!cs_active) begin
                rx_bit_q  <= '0;
                rx_byte_q <= '0;
                if (do_swap) rx_count_q <= '0;
            end else begin
                if (cs_fall) rx_count_q <= '0;
                if (sclk_rise) begin
                    rx_shift_q <= {rx_shift_q[DATA_WIDTH-3:0], mosi2_q};
                    if (rx_byte_done) begin
                        rx_bit_q <= '0;
                        if (rx_byte_q == BYTE_W'(BYTES - 1)) rx_byte_q <= '0;
                        else                                  rx_byte_q <= rx_byte_q + 1'b1;
                    end else begin
                        rx_bit_q <= rx_bit_q + 1'b1;
                    end
                end
                if (rx_word_done && rx_count_q != BUF_FULL) rx_count_q <= rx_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rx_word_done && rx_count_q != BUF_FULL) begin
            rx_mem[bank_q][rx_count_q[IDX_W-1:0]] <= {rx_shift_q, mosi2_q};
        end
    end

    assign miso = miso_q & cs_active;

endmodule

// File: tb/tb_nitta_spi_slave_pu.sv
// Bench for nitta_spi_slave_pu: table of core operations plus scripted SPI master transfers,
// with expected words queued when stimulus is issued and compared as results appear.
module tb_nitta_spi_slave_pu;
    localparam int H = 10;  // sclk half-period in clk cycles

    logic        clk = 1'b0;
    logic        rst, signal_cycle, signal_wr, signal_oe, mosi, sclk, cs, miso;
    logic [31:0] data_in, data_out;
    logic [3:0]  attr_in, attr_out;

    nitta_spi_slave_pu #(
        .DATA_WIDTH    (32),
        .ATTR_WIDTH    (4),
        .SPI_DATA_WIDTH(8),
        .BUF_SIZE      (8),
        .BOUNCE_FILTER (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .signal_cycle(signal_cycle),
        .signal_wr   (signal_wr),
        .data_in     (data_in),
        .attr_in     (attr_in),
        .signal_oe   (signal_oe),
        .data_out    (data_out),
        .attr_out    (attr_out),
        .mosi        (mosi),
        .miso        (miso),
        .sclk        (sclk),
        .cs          (cs)
    );

    always #5 clk = ~clk;

    typedef enum int {OpCyc, OpWr, OpOe} op_e;
    typedef struct {
        op_e         op;
        logic [31:0] data;
        logic        inv;
    } vec_t;

    vec_t        tbl[$];
    logic [35:0] rd_q[$];
    logic [31:0] spi_q[$];
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add(input op_e op, input logic [31:0] d, input logic inv);
        vec_t v;
        v.op   = op;
        v.data = d;
        v.inv  = inv;
        tbl.push_back(v);
    endtask

    task automatic core_read(input string name, input logic [31:0] d, input logic inv);
        logic [35:0] e;
        signal_oe = 1'b1;
        rd_q.push_back(inv ? {4'h1, 32'h0} : {4'h0, d});
        #3;
        e = rd_q.pop_front();
        check(name, {attr_out, data_out}, e);
        wait_clk(1);
        signal_oe = 1'b0;
    endtask

    task automatic run_ops(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            case (tbl[i].op)
                OpCyc: begin
                    signal_cycle = 1'b1;
                    wait_clk(1);
                    signal_cycle = 1'b0;
                end
                OpWr: begin
                    signal_wr = 1'b1;
                    data_in   = tbl[i].data;
                    wait_clk(1);
                    signal_wr = 1'b0;
                end
                default: core_read($sformatf("read_row%0d", i), tbl[i].data, tbl[i].inv);
            endcase
        end
    endtask

    function automatic logic [31:0] chunk(input logic [319:0] v, input int nbits, input int k);
        int           rem;
        logic [319:0] s;
        rem = nbits - 32 * k;
        if (rem >= 32) s = v >> (rem - 32);
        else           s = v & ((320'd1 << rem) - 320'd1);
        return s[31:0];
    endfunction

    // Mode-0 master; glitch names a bit whose low and high phases each get a 1-clk spike.
    task automatic spi_xfer(input int nbits, input logic [319:0] mo, input int glitch,
                            output logic [319:0] mi);
        mi = '0;
        cs = 1'b0;
        wait_clk(2 * H);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = mo[i];
            if (i == glitch) begin
                wait_clk(5); sclk = 1'b1; wait_clk(1); sclk = 1'b0; wait_clk(H - 6);
            end else begin
                wait_clk(H);
            end
            mi[i] = miso;
            sclk  = 1'b1;
            if (i == glitch) begin
                wait_clk(5); sclk = 1'b0; wait_clk(1); sclk = 1'b1; wait_clk(H - 6);
            end else begin
                wait_clk(H);
            end
            sclk = 1'b0;
        end
        wait_clk(H);
        cs   = 1'b1;
        mosi = 1'b0;
        wait_clk(2 * H);
    endtask

    task automatic xfer_check(input string name, input int nbits, input logic [319:0] mo,
                              input logic [319:0] exp_mi, input int glitch);
        logic [319:0] mi;
        int           nw;
        nw = (nbits + 31) / 32;
        for (int k = 0; k < nw; k++) spi_q.push_back(chunk(exp_mi, nbits, k));
        spi_xfer(nbits, mo, glitch, mi);
        for (int k = 0; k < nw; k++) begin
            check($sformatf("%s_word%0d", name, k), {4'h0, chunk(mi, nbits, k)},
                  {4'h0, spi_q.pop_front()});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed",
                 n_pass, n_total);
        $fatal(1);
    end

    initial begin
        logic [319:0] ovf_mo, ovf_exp;

        rst = 1'b1; signal_cycle = 1'b0; signal_wr = 1'b0; signal_oe = 1'b0;
        data_in = '0; attr_in = '0; mosi = 1'b0; sclk = 1'b0; cs = 1'b1;

        add(OpCyc, 32'h0, 1'b0);                                       // 0
        add(OpOe,  32'h0, 1'b1);                                       // 1
        add(OpWr,  32'hB0B1B2B3, 1'b0); add(OpWr, 32'hB4B5B6B7, 1'b0); // 2-3
        add(OpCyc, 32'h0, 1'b0);                                       // 4
        add(OpOe,  32'hA0A1A2A3, 1'b0); add(OpOe, 32'hA4A5A6A7, 1'b0); // 5-6
        add(OpOe,  32'h0, 1'b1);                                       // 7
        add(OpWr,  32'hE0E1E2E3, 1'b0); add(OpCyc, 32'h0, 1'b0);       // 8-9
        add(OpOe,  32'hF0F1F2F3, 1'b0); add(OpOe, 32'hF4F5F6F7, 1'b0); // 10-11
        add(OpOe,  32'h0, 1'b1);                                       // 12
        for (int k = 0; k < 9; k++) add(OpWr, 32'h9000_0000 | (k << 8) | k, 1'b0); // 13-21
        add(OpCyc, 32'h0, 1'b0);                                       // 22
        add(OpOe,  32'h11223344, 1'b0); add(OpOe, 32'h55667788, 1'b0); // 23-24
        add(OpOe,  32'h0, 1'b1);                                       // 25
        add(OpCyc, 32'h0, 1'b0);                                       // 26
        for (int k = 0; k < 8; k++) add(OpOe, 32'h1357_9000 | k, 1'b0); // 27-34
        add(OpOe,  32'h0, 1'b1);                                       // 35

        ovf_mo  = '0;
        ovf_exp = '0;
        for (int k = 0; k < 9; k++) ovf_mo = (ovf_mo << 32) | (32'h1357_9000 | k);
        ovf_mo = (ovf_mo << 16) | 320'hABCD;
        for (int k = 0; k < 8; k++) ovf_exp = (ovf_exp << 32) | (32'h9000_0000 | (k << 8) | k);
        ovf_exp = (ovf_exp << 48) | 320'hCCCCCCCC_CCCC;

        wait_clk(4);
        check("reset_data_attr", {attr_out, data_out}, 36'h0);
        check("reset_miso", {35'h0, miso}, 36'h0);
        rst = 1'b0;
        wait_clk(2);

        run_ops(0, 1);
        xfer_check("xfer_no_writes", 64, {256'h0, 64'hA0A1A2A3A4A5A6A7},
                   {256'h0, 64'hCCCCCCCCCCCCCCCC}, -1);
        run_ops(2, 7);
        xfer_check("xfer_send_b", 64, {256'h0, 64'hD0D1D2D3D4D5D6D7},
                   {256'h0, 64'hB0B1B2B3B4B5B6B7}, -1);
        run_ops(8, 9);

        fork
            xfer_check("xfer_pending", 64, {256'h0, 64'hF0F1F2F3F4F5F6F7},
                       {256'h0, 64'hE0E1E2E3CCCCCCCC}, -1);
            begin
                wait_clk(300);
                signal_cycle = 1'b1;
                wait_clk(1);
                signal_cycle = 1'b0;
                wait_clk(2);
                core_read("pending_read_old", 32'hD0D1D2D3, 1'b0);
                signal_wr = 1'b1;
                data_in   = 32'h6A6B6C6D;
                wait_clk(1);
                signal_wr = 1'b0;
            end
        join

        run_ops(10, 12);
        xfer_check("xfer_glitch", 64, {256'h0, 64'h1122334455667788},
                   {256'h0, 64'h6A6B6C6DCCCCCCCC}, 20);
        run_ops(13, 25);
        xfer_check("xfer_overflow", 304, ovf_mo, ovf_exp, -1);
        run_ops(26, 35);
        xfer_check("xfer_idle", 64, {256'h0, 64'h0123456789ABCDEF},
                   {256'h0, 64'hCCCCCCCCCCCCCCCC}, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
